// File: rtl/snn_cfg_pkg.sv
// Shared configuration for the SNN parameter-memory loader.
// Holds the command byte values, the controller state encoding and default sizes.
package snn_cfg_pkg;

    localparam int M_DEF = 162;
    localparam int N_DEF = 8;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_ERR
    } state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/snn_mem_load_ctrl_if.sv
// Byte-stream, memory-port and status bundle of the parameter-memory loader.
// master = the loader itself, slave = front-end, memory and network core around it.
interface snn_mem_load_ctrl_if
    import snn_cfg_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int N  = N_DEF,
    parameter int AW = $clog2(M)
);
    logic          frame_active;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_data_in;
    logic          mem_we;
    logic [N-1:0]  mem_data_out;
    logic [7:0]    tx_data;
    logic          tx_load;
    logic          busy;
    logic          load_done;
    logic          err;

    modport master (
        input  frame_active, rx_data, rx_valid, mem_data_out,
        output mem_addr, mem_data_in, mem_we, tx_data, tx_load, busy, load_done, err
    );

    modport slave (
        output frame_active, rx_data, rx_valid, mem_data_out,
        input  mem_addr, mem_data_in, mem_we, tx_data, tx_load, busy, load_done, err
    );

endinterface

// File: rtl/snn_mem_load_ctrl.sv
// Decodes framed command bytes into auto-incrementing burst writes/reads of the
// SNN parameter memory; every output comes straight from a register.
module snn_mem_load_ctrl
    import snn_cfg_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int N  = N_DEF,   // one rx byte per entry, so this stays 8
    parameter int AW = $clog2(M)
) (
    input  logic                   clk,
    input  logic                   reset,
    snn_mem_load_ctrl_if.master    bus
);

    state_e        state_q, state_d;
    logic          fa_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [7:0]    tx_q, tx_d;
    logic          txl_q, txl_d;
    logic          busy_q;
    logic          ld_q, ld_d;
    logic          err_q, err_d;
    logic          is_rd_q, is_rd_d;
    logic          pend_q, pend_d;
    logic          pzero_q, pzero_d;
    logic          full_q, full_d;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic          at_last;
    logic          wr_blocked;

    assign at_last    = (addr_q == AW'(M - 1));
    // The last entry may be written this very cycle, before full_q catches up.
    assign wr_blocked = full_q || (we_q && at_last);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        tx_d    = tx_q;
        txl_d   = 1'b0;
        ld_d    = 1'b0;
        err_d   = err_q;
        is_rd_d = is_rd_q;
        pend_d  = 1'b0;
        pzero_d = 1'b0;
        full_d  = full_q;
        wcnt_d  = wcnt_q;

        // Address advances the cycle after each write; it saturates at the last entry.
        if (we_q) begin
            if (at_last) full_d = 1'b1;
            else         addr_d = addr_q + 1'b1;
        end

        if (state_q == S_IDLE) begin
            wcnt_d = '0;
            full_d = 1'b0;
            if (bus.frame_active && !fa_q) begin
                state_d = S_CMD;
                err_d   = 1'b0;
            end
        end else if (!bus.frame_active) begin
            state_d = S_IDLE;
            if (state_q == S_WRITE && wcnt_q != '0) ld_d = 1'b1;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (bus.rx_valid) begin
                        if (is_cmd(bus.rx_data)) begin
                            state_d = S_ADDR;
                            is_rd_d = (bus.rx_data == CMD_READ);
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        if (int'(bus.rx_data) >= M) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            addr_d  = AW'(bus.rx_data);
                            full_d  = 1'b0;
                            state_d = is_rd_q ? S_READ : S_WRITE;
                            pend_d  = is_rd_q;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.rx_valid) begin
                        if (wr_blocked) begin
                            err_d = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = N'(bus.rx_data);
                            wcnt_d  = wcnt_q + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // pend_q: address settled last cycle, so mem_data_out is now valid.
                    if (pend_q) begin
                        txl_d = 1'b1;
                        tx_d  = pzero_q ? 8'h00 : 8'(bus.mem_data_out);
                    end
                    if (bus.rx_valid) begin
                        pend_d = 1'b1;
                        if (at_last) begin
                            pzero_d = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fa_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            tx_q    <= '0;
            txl_q   <= 1'b0;
            busy_q  <= 1'b0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            is_rd_q <= 1'b0;
            pend_q  <= 1'b0;
            pzero_q <= 1'b0;
            full_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fa_q    <= bus.frame_active;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            tx_q    <= tx_d;
            txl_q   <= txl_d;
            busy_q  <= (state_d != S_IDLE);
            ld_q    <= ld_d;
            err_q   <= err_d;
            is_rd_q <= is_rd_d;
            pend_q  <= pend_d;
            pzero_q <= pzero_d;
            full_q  <= full_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.mem_we      = we_q;
    assign bus.tx_data     = tx_q;
    assign bus.tx_load     = txl_q;
    assign bus.busy        = busy_q;
    assign bus.load_done   = ld_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_snn_mem_load_ctrl.sv
// Bench for snn_mem_load_ctrl: a frame-level model predicts writes, readback bytes,
// load_done and err; a per-cycle compare process checks the DUT memory and tx ports.
module tb_snn_mem_load_ctrl;
    import snn_cfg_pkg::*;

    localparam int M  = 162;
    localparam int N  = 8;
    localparam int AW = $clog2(M);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    snn_mem_load_ctrl_if #(.M(M), .N(N), .AW(AW)) bus_if();

    snn_mem_load_ctrl #(.M(M), .N(N), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Memory attached to the DUT port (the environment, not the model).
    logic [7:0] dmem [M];
    logic       init_mem = 1'b1;
    assign bus_if.mem_data_out = dmem[bus_if.mem_addr];

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 3) ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < M; i++) dmem[i] <= init_val(i);
        end else if (bus_if.mem_we) begin
            dmem[bus_if.mem_addr] <= bus_if.mem_data_in;
        end
    end

    // Frame-level model state
    logic [7:0]  model_mem [M];
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_tx [$];
    bit          exp_err;
    bit          exp_ld;
    int          ld_seen = 0;
    logic [7:0]  fb [16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Predict the effect of a frame carrying bytes fb[0..n-1] from the command rules.
    task automatic model_frame(input int n);
        int a;
        exp_err = 1'b0;
        exp_ld  = 1'b0;
        if (n == 0) return;
        if (fb[0] != 8'h01 && fb[0] != 8'h02) begin
            exp_err = 1'b1;
            return;
        end
        if (n < 2) return;
        a = int'(fb[1]);
        if (a >= M) begin
            exp_err = 1'b1;
            return;
        end
        if (fb[0] == 8'h01) begin
            for (int k = 2; k < n; k++) begin
                if (a < M) begin
                    exp_wr.push_back({8'(a), fb[k]});
                    model_mem[a] = fb[k];
                    a++;
                    exp_ld = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end else begin
            exp_tx.push_back(model_mem[a]);
            for (int k = 2; k < n; k++) begin
                if (a < M - 1) begin
                    a++;
                    exp_tx.push_back(model_mem[a]);
                end else begin
                    exp_tx.push_back(8'h00);
                    exp_err = 1'b1;
                end
            end
        end
    endtask

    // Per-cycle compare of write and readback traffic, sampled on the falling edge.
    logic [15:0] w_exp;
    logic [7:0]  t_exp;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.mem_we) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%0d data=%h expected no write",
                             bus_if.mem_addr, bus_if.mem_data_in);
                end else begin
                    w_exp = exp_wr.pop_front();
                    if ({bus_if.mem_addr, bus_if.mem_data_in} !== w_exp) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus_if.mem_addr, bus_if.mem_data_in, w_exp[15:8], w_exp[7:0]);
                    end
                end
            end
            if (bus_if.tx_load) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got tx_data=%h expected no tx_load", bus_if.tx_data);
                end else begin
                    t_exp = exp_tx.pop_front();
                    if (bus_if.tx_data !== t_exp) begin
                        errors++;
                        $display("FAIL tx: got tx_data=%h expected %h", bus_if.tx_data, t_exp);
                    end
                end
            end
            if (bus_if.load_done) ld_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send fb[0..n-1] back-to-back inside one frame; with drop_last the final byte
    // arrives in the same cycle that frame_active falls.
    task automatic do_frame(input string nm, input int n, input bit drop_last);
        int ld0;
        ld0 = ld_seen;
        model_frame(drop_last ? n - 1 : n);
        bus_if.frame_active = 1'b1;
        tick();
        chk({nm, "_busy_start"}, 32'(bus_if.busy), 32'd1);
        chk({nm, "_err_start"}, 32'(bus_if.err), 32'd0);
        for (int k = 0; k < (drop_last ? n - 1 : n); k++) begin
            bus_if.rx_data  = fb[k];
            bus_if.rx_valid = 1'b1;
            tick();
        end
        if (drop_last) begin
            bus_if.rx_data      = fb[n-1];
            bus_if.rx_valid     = 1'b1;
            bus_if.frame_active = 1'b0;
            tick();
            bus_if.rx_valid = 1'b0;
        end else begin
            bus_if.rx_valid = 1'b0;
            repeat (3) tick();
            bus_if.frame_active = 1'b0;
            tick();
        end
        chk({nm, "_busy_end"}, 32'(bus_if.busy), 32'd0);
        repeat (3) tick();
        chk({nm, "_load_done"}, 32'(ld_seen - ld0), 32'(exp_ld));
        chk({nm, "_err"}, 32'(bus_if.err), 32'(exp_err));
        chk({nm, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        chk({nm, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
        exp_wr.delete();
        exp_tx.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_addr"}, 32'(bus_if.mem_addr), 32'd0);
        chk({nm, "_mem_data_in"}, 32'(bus_if.mem_data_in), 32'd0);
        chk({nm, "_mem_we"}, 32'(bus_if.mem_we), 32'd0);
        chk({nm, "_tx_data"}, 32'(bus_if.tx_data), 32'd0);
        chk({nm, "_tx_load"}, 32'(bus_if.tx_load), 32'd0);
        chk({nm, "_busy"}, 32'(bus_if.busy), 32'd0);
        chk({nm, "_load_done"}, 32'(bus_if.load_done), 32'd0);
        chk({nm, "_err"}, 32'(bus_if.err), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < M; i++) model_mem[i] = init_val(i);
        bus_if.frame_active = 1'b0;
        bus_if.rx_data      = 8'h00;
        bus_if.rx_valid     = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        init_mem = 1'b0;
        reset    = 1'b0;
        repeat (2) tick();

        fb[0] = 8'h01; fb[1] = 8'h05; fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'hCC;
        do_frame("wr_burst", 5, 1'b0);
        chk("wr_burst_mem5", 32'(dmem[5]), 32'hAA);
        chk("wr_burst_mem7", 32'(dmem[7]), 32'hCC);

        fb[0] = 8'h02; fb[1] = 8'h05; fb[2] = 8'h00;
        do_frame("rd_burst", 3, 1'b0);
        chk("rd_burst_last_tx", 32'(bus_if.tx_data), 32'hBB);

        fb[0] = 8'h01; fb[1] = 8'hA1; fb[2] = 8'h11; fb[3] = 8'h22;
        do_frame("wr_top", 4, 1'b0);
        chk("wr_top_mem161", 32'(dmem[161]), 32'h11);
        chk("wr_top_mem160", 32'(dmem[160]), 32'(init_val(160)));

        fb[0] = 8'h02; fb[1] = 8'hA1; fb[2] = 8'h00;
        do_frame("rd_top", 3, 1'b0);
        chk("rd_top_last_tx", 32'(bus_if.tx_data), 32'h00);

        fb[0] = 8'h07;
        do_frame("bad_cmd", 1, 1'b0);
        chk("bad_cmd_err_lit", 32'(bus_if.err), 32'd1);

        fb[0] = 8'h01; fb[1] = 8'hA2;
        do_frame("bad_addr", 2, 1'b0);

        fb[0] = 8'h01; fb[1] = 8'h20; fb[2] = 8'h44; fb[3] = 8'h55;
        do_frame("fall_drop", 4, 1'b1);
        chk("fall_drop_mem20", 32'(dmem[8'h20]), 32'h44);
        chk("fall_drop_mem21", 32'(dmem[8'h21]), 32'(init_val(8'h21)));

        // Reset while a write strobe is on the memory port.
        bus_if.frame_active = 1'b1;
        tick();
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h01; tick();
        bus_if.rx_data  = 8'h10; tick();
        bus_if.rx_data  = 8'h33; tick();
        bus_if.rx_valid = 1'b0;
        chk("rst_mid_we_before", 32'(bus_if.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        bus_if.frame_active = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_mem10", 32'(dmem[8'h10]), 32'(init_val(8'h10)));

        fb[0] = 8'h01; fb[1] = 8'h10; fb[2] = 8'h77;
        do_frame("after_rst", 3, 1'b0);
        chk("after_rst_mem10", 32'(dmem[8'h10]), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snn_mem_load_ctrl.md
Name: snn_mem_load_ctrl

Overview:
Byte-stream sequencer that owns the write/read port of the SNN weight/delay parameter memory (M entries × N bits). It decodes framed command bytes from the serial front-end (SPI byte receiver) into burst writes with auto-incrementing address, and into burst readback toward the transmit shifter. It raises a load-done pulse when a write burst ends, so the network core can latch fresh parameters.

Parameters:
M, 162, number of memory entries
N, 8, entry width; must equal 8 (one rx byte per entry)
AW, $clog2(M), memory address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_active  in  1  chip-select level from front-end; high = frame in progress
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
mem_addr  out  AW  address to memory
mem_data_in  out  N  write data to memory
mem_we  out  1  memory write enable
mem_data_out  in  N  combinational read data from memory at mem_addr
tx_data  out  8  byte for transmit shifter
tx_load  out  1  one-cycle strobe, tx_data valid
busy  out  1  high in any state other than IDLE
load_done  out  1  one-cycle pulse at end of a write burst that wrote ≥1 byte
err  out  1  sticky error flag; cleared at next frame start

Behaviour:
- Clock/reset: single clock clk; reset asynchronous, active-high. On reset: state=IDLE, mem_addr=0, mem_data_in=0, mem_we=0, tx_data=0, tx_load=0, busy=0, load_done=0, err=0, write-count=0.
- All outputs registered.
- Command bytes: 0x01 = WRITE burst, 0x02 = READ burst; all other values are illegal.
- States: IDLE, CMD, ADDR, WRITE, READ, ERR.
- IDLE: on frame_active rising edge (registered compare) -> CMD; err cleared.
- CMD: on rx_valid, 0x01 or 0x02 -> ADDR (command remembered); any other value -> ERR, err=1.
- ADDR: on rx_valid, byte ≥ M -> ERR, err=1. Otherwise mem_addr<=byte next cycle, then -> WRITE or READ.
- WRITE: each rx_valid gives, next cycle, mem_data_in=rx_data, mem_we=1 for exactly one cycle at current mem_addr. mem_addr increments in the cycle after the write.
  - Write at address M-1: no wrap. mem_addr holds at M-1; further bytes are dropped (no mem_we), err=1, state stays WRITE.
- READ: one cycle after entry, tx_data<=mem_data_out, tx_load=1 (1 cycle). Each later rx_valid (dummy byte) increments mem_addr; the following cycle loads tx_data from the new address and pulses tx_load.
  - rx_valid at address M-1: mem_addr holds, tx_data=0x00 with tx_load pulse, err=1.
- ERR: ignore all rx_valid; mem_we never asserted.
- Frame end: frame_active low in any state -> IDLE next cycle, with priority over rx_valid in the same cycle (that byte is dropped).
  - If leaving WRITE with write-count ≥1: load_done=1 for one cycle. Write-count clears in IDLE.
- rx_valid while in IDLE, or while frame_active=0: ignored.
- Back-to-back rx_valid on consecutive cycles: supported in every state, no drops.
- Reset mid-burst: immediate IDLE, mem_we forced 0. Memory contents written before reset are not this block's concern.
- Write latency: rx_valid at cycle t -> mem_we at t+1 -> mem_addr+1 at t+2.

Decomposition:
- Shared package snn_cfg_pkg:
  - constants CMD_WRITE=8'h01, CMD_READ=8'h02
  - state enum encoding
  - defaults M=162, N=8
- No sub-module; a single FSM plus address counter. Optional helper snn_edge_detect for the frame_active rising edge.

Test Plan:
- Reset mid-WRITE -> all outputs 0 within the same cycle; state IDLE; next frame behaves normally.
- Frame [0x01,0x05,0xAA,0xBB,0xCC], back-to-back strobes -> mem_we pulses writing 5:AA, 6:BB, 7:CC; after frame_active falls, load_done one pulse; err=0.
- Preload 5:AA, 6:BB; frame [0x02,0x05,dummy] -> tx_load pulses with tx_data=0xAA then 0xBB; no mem_we.
- Frame [0x01,0xA1(=161),0x11,0x22] -> only mem[161]=0x11 written; 0x22 dropped; err=1; load_done pulses.
- Frame [0x07] -> ERR, err=1, no mem_we; frame [0x01,0xA2] -> err=1, no write; next frame start clears err.
- rx_valid in the same cycle as frame_active falls during WRITE -> no mem_we for that byte; IDLE next cycle.
